camera_qsys_nios2_gen2_cpu_ocimem_arbiter: RTL and testbench
============================================================

# camera_qsys_nios2_gen2_cpu_ocimem_arbiter

Shares the Nios II on-chip debug monitor RAM between two masters: JTAG debug commands decoded in the system-clock domain, and the CPU's Avalon debug memory slave. Single-port RAM with one-cycle registered read latency. Round-robin arbitration when both request together. JTAG commands are latched so none is lost. JTAG read data is returned on MonDReg.

## Interface
- ADDR_W, 8, RAM word-address width (2^ADDR_W 32-bit words)
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- jdo  in  38  JTAG command payload, valid in the cycle a take_* strobe is high
- take_action_ocimem_a  in  1  1-cycle strobe: load pointer = jdo[25:18]; if jdo[17]=1, also queue a read at the new pointer
- take_no_action_ocimem_a  in  1  1-cycle strobe: queue a read at the pointer
- take_action_ocimem_b  in  1  1-cycle strobe: queue a write of jdo[34:3] at the pointer
- MonDReg  out  32  last JTAG read data
- jtag_rd_done  out  1  1-cycle pulse when MonDReg updates
- jtag_busy  out  1  a JTAG command is pending or in service
- jtag_overrun  out  1  sticky: a strobe arrived while jtag_busy=1
- avs_address  in  ADDR_W  Avalon word address
- avs_read  in  1  Avalon read request
- avs_write  in  1  Avalon write request
- avs_writedata  in  32  Avalon write data
- avs_byteenable  in  4  Avalon byte enables
- avs_readdata  out  32  read data; valid when avs_waitrequest=0 during a read
- avs_waitrequest  out  1  request not yet accepted
- ram_addr  out  ADDR_W  RAM address, registered
- ram_wren  out  1  RAM write enable, registered
- ram_wdata  out  32  RAM write data, registered
- ram_byteen  out  4  RAM byte enables, registered
- ram_rdata  in  32  RAM read data, valid 1 cycle after ram_addr is presented

## Operation
- States: IDLE, AV_WR, AV_RD, AV_RDW, J_WR, J_RD, J_RDW.
- JTAG pending register:
  - Set by any take_* strobe when jtag_busy=0.
  - Captures command type, data and target address. The pointer update from ocimem_a takes effect in that same cycle.
  - Cleared when the command completes.
- A strobe while jtag_busy=1:
  - The command is ignored and the pointer is not changed.
  - jtag_overrun is set to 1 and stays 1 until reset.
- Avalon request pending = avs_read | avs_write.
  - If both are high, avs_write takes priority.
- Arbitration happens only in IDLE.
  - If only one requester is pending, it wins.
  - If both are pending, the requester not granted last wins.
  - last_grant resets to AVALON, so JTAG wins the first tie.
- IDLE -> AV_WR / AV_RD / J_WR / J_RD on grant. In the same edge, register ram_addr, ram_wdata and ram_byteen, and set ram_wren=1 for writes only.
- AV_WR: RAM write in progress; avs_waitrequest=0; -> IDLE.
- AV_RD: RAM samples the address; -> AV_RDW.
- AV_RDW: avs_readdata=ram_rdata; avs_waitrequest=0; -> IDLE.
- J_WR: RAM write with byteen=4'hF; pointer += 1; clear pending; -> IDLE.
- J_RD: RAM samples the address; -> J_RDW.
- J_RDW: MonDReg <= ram_rdata; jtag_rd_done=1 next cycle; pointer += 1; clear pending; -> IDLE.
- ram_wren is 1 only while in AV_WR or J_WR. It is 0 in all other states.
- Pointer arithmetic is modulo 2^ADDR_W: 255+1 wraps to 0.
- avs_waitrequest is 1 in every state except AV_WR and AV_RDW.

## Timing
- Reset values:
  - state=IDLE, pointer=0, pending=0, last_grant=AVALON.
  - MonDReg=0, jtag_rd_done=0, jtag_busy=0, jtag_overrun=0.
  - ram_wren=0, ram_addr=0, ram_wdata=0, ram_byteen=0.
  - avs_waitrequest=1, avs_readdata=0.
- Reset asserted mid-operation:
  - ram_wren drops immediately, so no partial write completes.
  - Any in-flight Avalon request stays stalled until reset is released.
  - Any pending JTAG command is discarded.
- Latency with the request present in IDLE at cycle N:
  - Avalon write: waitrequest=0 at N+1.
  - Avalon read: waitrequest=0 with readdata at N+2.
  - JTAG write: RAM written at N+1; jtag_busy=0 from N+2.
  - JTAG read: MonDReg valid and jtag_rd_done=1 at N+3.
- A strobe at cycle S sets pending at S+1. The earliest grant is then S+1 if the block is IDLE.
- Back-to-back operations always pass through one IDLE cycle. Maximum stall for either requester is one opposite operation (at most 3 cycles) plus its own.

## Test plan
- Reset, then Avalon write 0xDEADBEEF to address 0x10 with byteenable 4'hF -> ram_wren=1, ram_addr=0x10 one cycle after the request; waitrequest low in that same cycle.
- ocimem_a with jdo[25:18]=0x10 and jdo[17]=1 -> MonDReg=0xDEADBEEF and jtag_rd_done pulse 3 cycles after pending sets; pointer=0x11.
- Avalon read and JTAG write both pending in IDLE after reset -> JTAG granted first, then Avalon. Repeat the tie -> Avalon is granted first.
- Pointer at 0xFF, then ocimem_b with data 0x12345678 -> written at 0xFF; pointer wraps to 0x00.
- Second strobe arriving while jtag_busy=1 -> command ignored, pointer unchanged, jtag_overrun=1 until reset.
- Assert reset_n=0 while in AV_WR -> ram_wren=0 immediately, avs_waitrequest=1, state=IDLE after release.

Source files
------------

// File: rtl/camera_qsys_nios2_gen2_cpu_ocimem_arbiter_if.sv
// Avalon debug-memory slave bundle between the CPU side (master) and the
// OCI memory arbiter (slave).
interface camera_qsys_nios2_gen2_cpu_ocimem_arbiter_if #(
  parameter int ADDR_W = 8
) ();
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;
  logic              waitrequest;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, waitrequest
  );
endinterface

// File: rtl/camera_qsys_nios2_gen2_cpu_ocimem_arbiter.sv
// Round-robin arbiter sharing the single-port debug monitor RAM between
// latched JTAG commands and the CPU's Avalon debug memory slave.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | arbitrate between Avalon request and pending JTAG command
// AV_WR   | Avalon write presented to RAM, Avalon request accepted
// AV_RD   | RAM samples Avalon read address
// AV_RDW  | RAM data returned on readdata, Avalon request accepted
// J_WR    | JTAG write presented to RAM, pointer advances
// J_RD    | RAM samples JTAG read address
// J_RDW   | RAM data captured into MonDReg, pointer advances
module camera_qsys_nios2_gen2_cpu_ocimem_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [37:0]           jdo,
  input  logic                  take_action_ocimem_a,
  input  logic                  take_no_action_ocimem_a,
  input  logic                  take_action_ocimem_b,
  output logic [31:0]           MonDReg,
  output logic                  jtag_rd_done,
  output logic                  jtag_busy,
  output logic                  jtag_overrun,
  camera_qsys_nios2_gen2_cpu_ocimem_arbiter_if.slave avs,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic                  ram_wren,
  output logic [31:0]           ram_wdata,
  output logic [3:0]            ram_byteen,
  input  logic [31:0]           ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_AV_WR, S_AV_RD, S_AV_RDW, S_J_WR, S_J_RD, S_J_RDW
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] jtag_addr;
  logic [31:0]       jtag_data;
  logic              jtag_pend;
  logic              jtag_is_wr;
  logic              last_grant_jtag;
  logic              av_req;
  logic              grant_av;
  logic              grant_j;
  logic              any_strobe;
  logic              unused_jdo;

  assign av_req     = avs.read | avs.write;
  assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  assign jtag_busy       = jtag_pend;
  assign avs.waitrequest = !((state == S_AV_WR) || (state == S_AV_RDW));
  assign avs.readdata    = (state == S_AV_RDW) ? ram_rdata : '0;

  always_comb begin
    state_nxt = state;
    grant_av  = 1'b0;
    grant_j   = 1'b0;
    case (state)
      S_IDLE: begin
        // On a tie the side that did not win last time goes first
        if (av_req && jtag_pend) begin
          grant_j  = !last_grant_jtag;
          grant_av = last_grant_jtag;
        end else begin
          grant_av = av_req;
          grant_j  = jtag_pend;
        end
        if (grant_av)
          state_nxt = avs.write ? S_AV_WR : S_AV_RD;
        else if (grant_j)
          state_nxt = jtag_is_wr ? S_J_WR : S_J_RD;
      end
      S_AV_WR:  state_nxt = S_IDLE;
      S_AV_RD:  state_nxt = S_AV_RDW;
      S_AV_RDW: state_nxt = S_IDLE;
      S_J_WR:   state_nxt = S_IDLE;
      S_J_RD:   state_nxt = S_J_RDW;
      S_J_RDW:  state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      ptr             <= '0;
      jtag_addr       <= '0;
      jtag_data       <= '0;
      jtag_pend       <= 1'b0;
      jtag_is_wr      <= 1'b0;
      last_grant_jtag <= 1'b0;
      MonDReg         <= '0;
      jtag_rd_done    <= 1'b0;
      jtag_overrun    <= 1'b0;
      ram_addr        <= '0;
      ram_wren        <= 1'b0;
      ram_wdata       <= '0;
      ram_byteen      <= '0;
    end else begin
      state        <= state_nxt;
      jtag_rd_done <= (state == S_J_RDW);
      ram_wren     <= (state_nxt == S_AV_WR) || (state_nxt == S_J_WR);

      if (grant_av) begin
        ram_addr        <= avs.address;
        ram_wdata       <= avs.writedata;
        ram_byteen      <= avs.byteenable;
        last_grant_jtag <= 1'b0;
      end else if (grant_j) begin
        ram_addr        <= jtag_addr;
        ram_wdata       <= jtag_data;
        ram_byteen      <= 4'hF;
        last_grant_jtag <= 1'b1;
      end

      if (state == S_J_RDW)
        MonDReg <= ram_rdata;

      if (any_strobe && jtag_pend)
        jtag_overrun <= 1'b1;

      // A busy JTAG side ignores strobes entirely, so the pointer cannot move mid-command
      if ((state == S_J_WR) || (state == S_J_RDW)) begin
        jtag_pend <= 1'b0;
        ptr       <= ptr + 1'b1;
      end else if (!jtag_pend) begin
        if (take_action_ocimem_b) begin
          jtag_pend  <= 1'b1;
          jtag_is_wr <= 1'b1;
          jtag_data  <= jdo[34:3];
          jtag_addr  <= ptr;
        end else if (take_action_ocimem_a) begin
          ptr <= jdo[18 +: ADDR_W];
          if (jdo[17]) begin
            jtag_pend  <= 1'b1;
            jtag_is_wr <= 1'b0;
            jtag_addr  <= jdo[18 +: ADDR_W];
          end
        end else if (take_no_action_ocimem_a) begin
          jtag_pend  <= 1'b1;
          jtag_is_wr <= 1'b0;
          jtag_addr  <= ptr;
        end
      end
    end
  end

endmodule

// File: tb/tb_camera_qsys_nios2_gen2_cpu_ocimem_arbiter.sv
// Self-checking bench: RAM behavioural model plus a shadow-memory / pointer
// reference model driven by randomized and directed JTAG and Avalon traffic.
module tb_camera_qsys_nios2_gen2_cpu_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic        take_action_ocimem_a = 1'b0;
  logic        take_no_action_ocimem_a = 1'b0;
  logic        take_action_ocimem_b = 1'b0;
  logic [31:0] MonDReg;
  logic        jtag_rd_done, jtag_busy, jtag_overrun;
  logic [7:0]  ram_addr;
  logic        ram_wren;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_byteen;
  logic [31:0] ram_rdata;

  camera_qsys_nios2_gen2_cpu_ocimem_arbiter_if #(.ADDR_W(8)) avs ();

  camera_qsys_nios2_gen2_cpu_ocimem_arbiter #(.ADDR_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .MonDReg(MonDReg), .jtag_rd_done(jtag_rd_done), .jtag_busy(jtag_busy),
    .jtag_overrun(jtag_overrun), .avs(avs),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_wdata(ram_wdata),
    .ram_byteen(ram_byteen), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM: byte-enabled write, one-cycle registered read
  logic [31:0] mem [256];
  logic        mem_load = 1'b0;
  logic [31:0] model_mem [256];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= model_mem[i];
    end else if (ram_wren) begin
      for (int b = 0; b < 4; b++)
        if (ram_byteen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    ram_rdata <= mem[ram_addr];
  end

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_ptr;
  logic       model_last_jtag;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    reset_n = 1'b0;
    avs.read = 1'b0; avs.write = 1'b0;
    take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    model_ptr = 8'h00;
    model_last_jtag = 1'b0;
  endtask

  task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++)
      if (be[b]) model_mem[a][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic av_op(input logic wr, input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    int cyc;
    logic [31:0] exp_rd;
    @(posedge clk); #1;
    avs.address = a; avs.writedata = d; avs.byteenable = be;
    avs.write = wr; avs.read = !wr;
    exp_rd = model_mem[a];
    @(negedge clk);
    cyc = 0;
    while (avs.waitrequest && cyc < 10) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc !== (wr ? 1 : 2)) begin errors++; $display("FAIL av_latency wr=%0d: got %0d cycles, exp %0d", wr, cyc, wr ? 1 : 2); end
    if (wr) begin
      checks++;
      if (ram_wren !== 1'b1 || ram_addr !== a || ram_wdata !== d || ram_byteen !== be) begin
        errors++;
        $display("FAIL av_write_bus: got wren=%b addr=%h data=%h be=%h, exp 1 %h %h %h", ram_wren, ram_addr, ram_wdata, ram_byteen, a, d, be);
      end
      model_write(a, d, be);
    end else begin
      checks++;
      if (avs.readdata !== exp_rd) begin errors++; $display("FAIL av_readdata @%h: got %h exp %h", a, avs.readdata, exp_rd); end
    end
    model_last_jtag = 1'b0;
    @(posedge clk); #1;
    avs.write = 1'b0; avs.read = 1'b0;
  endtask

  // kind 0: ocimem_a (load pointer, optional read), 1: no_action read, 2: ocimem_b write
  task automatic jtag_cmd(input int kind, input logic [7:0] a, input logic rd, input logic [31:0] d);
    logic [37:0] j;
    logic        queued, is_wr;
    logic [7:0]  tgt;
    int          cyc;
    logic        done, addr_ok;
    j = {6'($urandom), $urandom()};
    if (kind == 0) begin j[25:18] = a; j[17] = rd; end
    if (kind == 2) j[34:3] = d;
    if (kind == 0) model_ptr = a;
    queued = (kind != 0) || rd;
    is_wr  = (kind == 2);
    tgt    = model_ptr;
    @(posedge clk); #1;
    jdo = j;
    take_action_ocimem_a    = (kind == 0);
    take_no_action_ocimem_a = (kind == 1);
    take_action_ocimem_b    = (kind == 2);
    @(posedge clk); #1;
    take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
    @(negedge clk);
    if (!queued) return;
    checks++;
    if (jtag_busy !== 1'b1) begin errors++; $display("FAIL jtag_busy_set: got %b exp 1", jtag_busy); end
    cyc = 0; done = 1'b0; addr_ok = 1'b0;
    while (!done && cyc < 10) begin
      @(negedge clk); cyc++;
      if (cyc == 1)
        addr_ok = (ram_addr == tgt) && (ram_wren == is_wr) && (!is_wr || (ram_wdata == d && ram_byteen == 4'hF));
      done = is_wr ? !jtag_busy : jtag_rd_done;
    end
    checks++;
    if (!addr_ok) begin errors++; $display("FAIL jtag_ram_access: got addr=%h wren=%b data=%h, exp addr=%h wren=%b", ram_addr, ram_wren, ram_wdata, tgt, is_wr); end
    checks++;
    if (cyc !== (is_wr ? 2 : 3)) begin errors++; $display("FAIL jtag_latency wr=%0d: got %0d exp %0d", is_wr, cyc, is_wr ? 2 : 3); end
    if (is_wr) model_write(tgt, d, 4'hF);
    else begin
      checks++;
      if (MonDReg !== model_mem[tgt]) begin errors++; $display("FAIL mondreg @%h: got %h exp %h", tgt, MonDReg, model_mem[tgt]); end
    end
    model_ptr = model_ptr + 8'd1;
    model_last_jtag = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if (MonDReg !== 32'h0 || jtag_rd_done !== 1'b0 || jtag_busy !== 1'b0 || jtag_overrun !== 1'b0) begin
      errors++; $display("FAIL reset_jtag: got mon=%h done=%b busy=%b ovr=%b exp all 0", MonDReg, jtag_rd_done, jtag_busy, jtag_overrun);
    end
    checks++;
    if (ram_wren !== 1'b0 || ram_addr !== 8'h0 || ram_wdata !== 32'h0 || ram_byteen !== 4'h0) begin
      errors++; $display("FAIL reset_ram: got wren=%b addr=%h data=%h be=%h exp all 0", ram_wren, ram_addr, ram_wdata, ram_byteen);
    end
    checks++;
    if (avs.waitrequest !== 1'b1 || avs.readdata !== 32'h0) begin
      errors++; $display("FAIL reset_avs: got wait=%b rdata=%h exp 1 0", avs.waitrequest, avs.readdata);
    end
  endtask

  task automatic test_av_write();
    av_op(1'b1, 8'h10, 32'hDEADBEEF, 4'hF);
  endtask

  task automatic test_jtag_read();
    jtag_cmd(0, 8'h10, 1'b1, 32'h0);
    @(negedge clk);
    checks++;
    if (jtag_rd_done !== 1'b0) begin errors++; $display("FAIL rd_done_pulse: got %b exp 0", jtag_rd_done); end
    checks++;
    if (MonDReg !== 32'hDEADBEEF) begin errors++; $display("FAIL mondreg_directed: got %h exp deadbeef", MonDReg); end
  endtask

  task automatic tie_once(input logic [31:0] d);
    logic        jtag_wins;
    logic [7:0]  p;
    logic [31:0] exp_rd, got_rd;
    int          k_j, k_av, exp_kj, exp_kav;
    p = model_ptr;
    jtag_wins = !model_last_jtag;
    @(posedge clk); #1;
    jdo = {3'b000, d, 3'b000};
    take_action_ocimem_b = 1'b1;
    @(posedge clk); #1;
    take_action_ocimem_b = 1'b0;
    avs.address = p; avs.read = 1'b1; avs.write = 1'b0; avs.byteenable = 4'hF;
    if (jtag_wins) model_write(p, d, 4'hF);
    exp_rd = model_mem[p];
    if (!jtag_wins) model_write(p, d, 4'hF);
    exp_kj  = jtag_wins ? 1 : 4;
    exp_kav = jtag_wins ? 4 : 2;
    k_j = 0; k_av = 0; got_rd = '0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k_av != 0) avs.read = 1'b0;
      @(negedge clk);
      if (k_j == 0 && ram_wren) k_j = k;
      if (k_av == 0 && !avs.waitrequest) begin k_av = k; got_rd = avs.readdata; end
    end
    avs.read = 1'b0;
    checks++;
    if (k_j !== exp_kj) begin errors++; $display("FAIL tie_jtag_slot: got %0d exp %0d", k_j, exp_kj); end
    checks++;
    if (k_av !== exp_kav) begin errors++; $display("FAIL tie_avs_slot: got %0d exp %0d", k_av, exp_kav); end
    checks++;
    if (got_rd !== exp_rd) begin errors++; $display("FAIL tie_readdata: got %h exp %h", got_rd, exp_rd); end
    model_ptr = model_ptr + 8'd1;
    model_last_jtag = !jtag_wins;
  endtask

  task automatic test_tie();
    apply_reset();
    tie_once(32'hA5A5_0001);
    jtag_cmd(1, 8'h00, 1'b0, 32'h0);
    tie_once(32'h5A5A_0002);
  endtask

  task automatic test_ptr_wrap();
    jtag_cmd(0, 8'hFF, 1'b0, 32'h0);
    jtag_cmd(2, 8'h00, 1'b0, 32'h12345678);
    checks++;
    if (model_ptr !== 8'h00) begin errors++; $display("FAIL wrap_model: got %h exp 00", model_ptr); end
    jtag_cmd(1, 8'h00, 1'b0, 32'h0);
    av_op(1'b0, 8'hFF, 32'h0, 4'hF);
  endtask

  task automatic test_random();
    int kind;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: av_op(1'b1, 8'($urandom), $urandom(), 4'($urandom));
        1: av_op(1'b0, 8'($urandom), 32'h0, 4'($urandom));
        2: jtag_cmd(0, 8'($urandom), 1'($urandom), 32'h0);
        3: jtag_cmd(1, 8'h00, 1'b0, 32'h0);
        default: jtag_cmd(2, 8'h00, 1'b0, $urandom());
      endcase
    end
    checks++;
    if (jtag_overrun !== 1'b0) begin errors++; $display("FAIL overrun_spurious: got %b exp 0", jtag_overrun); end
  endtask

  task automatic test_overrun();
    logic [7:0] p;
    int cyc;
    p = model_ptr;
    @(posedge clk); #1;
    take_no_action_ocimem_a = 1'b1;
    @(posedge clk); #1;
    take_no_action_ocimem_a = 1'b0;
    jdo = '0; jdo[25:18] = p + 8'h40; jdo[17] = 1'b1;
    take_action_ocimem_a = 1'b1;
    @(posedge clk); #1;
    take_action_ocimem_a = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!jtag_rd_done && cyc < 10);
    checks++;
    if (cyc !== 3) begin errors++; $display("FAIL overrun_latency: got %0d exp 3", cyc); end
    checks++;
    if (MonDReg !== model_mem[p]) begin errors++; $display("FAIL overrun_mondreg: got %h exp %h", MonDReg, model_mem[p]); end
    checks++;
    if (jtag_overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b exp 1", jtag_overrun); end
    model_ptr = model_ptr + 8'd1;
    model_last_jtag = 1'b1;
    jtag_cmd(1, 8'h00, 1'b0, 32'h0);
    checks++;
    if (jtag_overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b exp 1", jtag_overrun); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    d = model_mem[8'h20] ^ 32'hFFFF_FFFF;
    @(posedge clk); #1;
    avs.address = 8'h20; avs.writedata = d; avs.byteenable = 4'hF; avs.write = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ram_wren !== 1'b1) begin errors++; $display("FAIL midreset_pre: got wren=%b exp 1", ram_wren); end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (ram_wren !== 1'b0 || avs.waitrequest !== 1'b1) begin
      errors++; $display("FAIL midreset_now: got wren=%b wait=%b exp 0 1", ram_wren, avs.waitrequest);
    end
    @(negedge clk);
    checks++;
    if (avs.waitrequest !== 1'b1) begin errors++; $display("FAIL midreset_stall: got %b exp 1", avs.waitrequest); end
    @(posedge clk); #1 avs.write = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    model_ptr = 8'h00;
    model_last_jtag = 1'b0;
    @(negedge clk);
    checks++;
    if (ram_wren !== 1'b0 || avs.waitrequest !== 1'b1 || jtag_overrun !== 1'b0 || jtag_busy !== 1'b0) begin
      errors++; $display("FAIL midreset_after: got wren=%b wait=%b ovr=%b busy=%b exp 0 1 0 0", ram_wren, avs.waitrequest, jtag_overrun, jtag_busy);
    end
    av_op(1'b0, 8'h20, 32'h0, 4'hF);
    jtag_cmd(1, 8'h00, 1'b0, 32'h0);
  endtask

  initial begin
    avs.address = '0; avs.read = 1'b0; avs.write = 1'b0;
    avs.writedata = '0; avs.byteenable = '0;
    for (int i = 0; i < 256; i++) model_mem[i] = $urandom();
    mem_load = 1'b1;
    @(posedge clk); #1 mem_load = 1'b0;
    test_reset();
    test_av_write();
    test_jtag_read();
    test_tie();
    test_ptr_wrap();
    test_random();
    test_overrun();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
